// File: rtl/axis_sc16_cmul_pkg.sv
// Shared sc16 fixed-point definitions: sample type, Q0.15 limits and the
// round-half-away / saturate helper used by the S3 stage.
package PkgSc16Fixed;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } sc16_t;

    typedef struct packed {
        logic               sat;
        logic signed [15:0] val;
    } q15_rs_t;

    localparam logic signed [15:0] S16_MAX = 16'sh7FFF;
    localparam logic signed [15:0] S16_MIN = 16'sh8000;

    localparam logic signed [18:0] Q_MAX = 19'sd32767;
    localparam logic signed [18:0] Q_MIN = -19'sd32768;

    // Q2.30 -> Q0.15: bias by just under half an LSB for negatives so ties round away from zero.
    function automatic q15_rs_t round_sat_q15(input logic signed [32:0] v);
        logic signed [33:0] t;
        logic signed [18:0] q;
        q15_rs_t            r;
        t = 34'(v) + (v[32] ? 34'sd16383 : 34'sd16384);
        q = 19'(t >>> 15);
        if (q > Q_MAX) begin
            r.sat = 1'b1;
            r.val = S16_MAX;
        end else if (q < Q_MIN) begin
            r.sat = 1'b1;
            r.val = S16_MIN;
        end else begin
            r.sat = 1'b0;
            r.val = q[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_sc16_cmul_round_sat.sv
// sc16_round_sat: combinational rounding and clipping of a Q2.30 complex
// pair down to sc16, with a combined saturation flag.
module sc16_round_sat
    import PkgSc16Fixed::*;
(
    input  logic signed [32:0] re_i,
    input  logic signed [32:0] im_i,
    output sc16_t              y_o,
    output logic               sat_o
);

    logic signed [32:0] lane_in  [2];
    q15_rs_t            lane_out [2];

    assign lane_in[0] = re_i;
    assign lane_in[1] = im_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_out[gi] = round_sat_q15(lane_in[gi]);
        end
    endgenerate

    assign y_o.re = lane_out[0].val;
    assign y_o.im = lane_out[1].val;
    assign sat_o  = lane_out[0].sat | lane_out[1].sat;

endmodule

// File: rtl/axis_sc16_cmul.sv
// Streaming sc16 complex multiplier, 3-stage (multiply, add, round/clip) AXI-Stream pipe.
// Optional: define AXIS_SC16_CMUL_CONJ_EN to compute x * conj(y) instead of x * y.
module axis_sc16_cmul
    import PkgSc16Fixed::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int USER_W     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       i_tdata,
    input  logic [USER_W-1:0] i_tuser,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic [31:0]       o_tdata,
    output logic [USER_W-1:0] o_tuser,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic              o_sat
);

    generate
        if (PIPE_DEPTH != 3) begin : g_bad_depth
            $error("axis_sc16_cmul: PIPE_DEPTH must be 3");
        end
    endgenerate

    logic signed [15:0] xr, xi, yr, yi, yi_c;
    assign xr = i_tdata[63:48];
    assign xi = i_tdata[47:32];
    assign yr = i_tdata[31:16];
    assign yi = i_tdata[15:0];

`ifdef AXIS_SC16_CMUL_CONJ_EN
    // -(-1.0) is not representable; clip it to the largest positive value.
    assign yi_c = (yi == S16_MIN) ? S16_MAX : -yi;
`else
    assign yi_c = yi;
`endif

    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic ld1, ld2, ld3;

    assign ld3      = !v3_q || o_tready;
    assign ld2      = !v2_q || ld3;
    assign ld1      = !v1_q || ld2;
    assign i_tready = ld1;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (ld1) v1_d = i_tvalid;
        if (ld2) v2_d = v1_q;
        if (ld3) v3_d = v2_q;
    end

    logic signed [31:0] rr_q, ii_q, ri_q, ir_q;
    logic               last1_q, last2_q, last3_q;
    logic [USER_W-1:0]  user1_q, user2_q, user3_q;
    logic signed [32:0] re_q, im_q;
    sc16_t              dat3_q, rs_y;
    logic               sat3_q, rs_sat;

    sc16_round_sat u_round_sat (
        .re_i  (re_q),
        .im_i  (im_q),
        .y_o   (rs_y),
        .sat_o (rs_sat)
    );

    // S1/S2 payload needs no reset: it is only observed behind its valid bit.
    always_ff @(posedge clk) begin
        if (ld1 && i_tvalid) begin
            rr_q    <= 32'(xr) * 32'(yr);
            ii_q    <= 32'(xi) * 32'(yi_c);
            ri_q    <= 32'(xr) * 32'(yi_c);
            ir_q    <= 32'(xi) * 32'(yr);
            last1_q <= i_tlast;
            user1_q <= i_tuser;
        end
        if (ld2 && v1_q) begin
            re_q    <= 33'(rr_q) - 33'(ii_q);
            im_q    <= 33'(ri_q) + 33'(ir_q);
            last2_q <= last1_q;
            user2_q <= user1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            dat3_q  <= '0;
            sat3_q  <= 1'b0;
            last3_q <= 1'b0;
            user3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (ld3 && v2_q) begin
                dat3_q  <= rs_y;
                sat3_q  <= rs_sat;
                last3_q <= last2_q;
                user3_q <= user2_q;
            end
        end
    end

    assign o_tvalid = v3_q;
    assign o_tdata  = dat3_q;
    assign o_sat    = sat3_q;
    assign o_tlast  = last3_q;
    assign o_tuser  = user3_q;

endmodule

// File: tb/tb_axis_sc16_cmul.sv
// Self-checking bench for axis_sc16_cmul: scoreboard fed at input handshake,
// drained at output handshake, plus directed latency/stall/reset scenarios.
module tb_axis_sc16_cmul;
    import PkgSc16Fixed::*;

    localparam int USER_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [63:0]       i_tdata = '0;
    logic [USER_W-1:0] i_tuser = '0;
    logic              i_tlast = 1'b0;
    logic              i_tvalid = 1'b0;
    logic              i_tready;
    logic [31:0]       o_tdata;
    logic [USER_W-1:0] o_tuser;
    logic              o_tlast;
    logic              o_tvalid;
    logic              o_tready = 1'b1;
    logic              o_sat;

    axis_sc16_cmul #(.PIPE_DEPTH(3), .USER_W(USER_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_tdata  (i_tdata),
        .i_tuser  (i_tuser),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tuser  (o_tuser),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_sat    (o_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       data;
        logic              sat;
        logic              last;
        logic [USER_W-1:0] user;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   out_count = 0;

    // Independent reference: round half away from zero on magnitudes, then clip.
    function automatic logic [16:0] ref_rnd(input longint v);
        longint m, q;
        m = (v < 0) ? -v : v;
        q = (m + 16384) / 32768;
        if (v < 0) q = -q;
        if (q > 32767) return {1'b1, S16_MAX};
        if (q < -32768) return {1'b1, S16_MIN};
        return {1'b0, q[15:0]};
    endfunction

    function automatic logic [32:0] ref_cmul(input logic [63:0] d);
        longint xr, xi, yr, yi, re, im;
        logic [16:0] r, i;
        xr = longint'($signed(d[63:48]));
        xi = longint'($signed(d[47:32]));
        yr = longint'($signed(d[31:16]));
        yi = longint'($signed(d[15:0]));
`ifdef AXIS_SC16_CMUL_CONJ_EN
        yi = (yi == -32768) ? 32767 : -yi;
`endif
        re = xr * yr - xi * yi;
        im = xr * yi + xi * yr;
        r = ref_rnd(re);
        i = ref_rnd(im);
        return {r[16] | i[16], r[15:0], i[15:0]};
    endfunction

    // Scoreboard monitor; also checks output stability while stalled.
    logic [31:0]       hd;
    logic              hs, hl;
    logic [USER_W-1:0] hu;
    bit                hold = 0;
    always @(negedge clk) begin
        exp_t        e;
        logic [32:0] m;
        if (rst) begin
            sb.delete();
            hold = 0;
        end else begin
            if (hold) begin
                checks++;
                if (o_tvalid !== 1'b1 || o_tdata !== hd || o_sat !== hs || o_tlast !== hl || o_tuser !== hu) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b d=%h s=%b l=%b u=%h need v=1 d=%h s=%b l=%b u=%h",
                             o_tvalid, o_tdata, o_sat, o_tlast, o_tuser, hd, hs, hl, hu);
                end
            end
            hold = o_tvalid && !o_tready;
            hd = o_tdata; hs = o_sat; hl = o_tlast; hu = o_tuser;
            if (o_tvalid && o_tready) begin
                out_count++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got d=%h with empty scoreboard", o_tdata);
                end else begin
                    e = sb.pop_front();
                    if ({o_tdata, o_sat, o_tlast, o_tuser} !== {e.data, e.sat, e.last, e.user}) begin
                        errors++;
                        $display("FAIL beat: got d=%h s=%b l=%b u=%h need d=%h s=%b l=%b u=%h",
                                 o_tdata, o_sat, o_tlast, o_tuser, e.data, e.sat, e.last, e.user);
                    end
                end
            end
            if (i_tvalid && i_tready) begin
                m = ref_cmul(i_tdata);
                e.data = m[31:0];
                e.sat  = m[32];
                e.last = i_tlast;
                e.user = i_tuser;
                sb.push_back(e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present one beat from posedge+1 until accepted; returns at posedge+1 after acceptance.
    task automatic send_beat(input logic [63:0] d, input logic last, input logic [USER_W-1:0] u,
                             output int waits);
        i_tdata = d; i_tlast = last; i_tuser = u; i_tvalid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (i_tready) break;
            waits++;
            if (waits > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout: i_tready stuck at %b, need 1", i_tready);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats pending, need 0", name, sb.size());
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick_s16();
        logic [15:0] t;
        case ($urandom_range(0, 5))
            0: t = 16'h8000;
            1: t = 16'h7FFF;
            2: t = 16'h0001;
            3: t = 16'hFFFF;
            default: t = 16'($urandom);
        endcase
        return t;
    endfunction

    task automatic test_reset();
        rst = 1'b1; i_tvalid = 1'b0; o_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_tvalid, o_sat, o_tlast} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got v/s/l=%b%b%b need 000", o_tvalid, o_sat, o_tlast);
        end
        checks++;
        if (o_tdata !== 32'h0 || o_tuser !== '0) begin
            errors++;
            $display("FAIL reset_data: got d=%h u=%h need 0", o_tdata, o_tuser);
        end
        checks++;
        if (i_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b need 1", i_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [63:0] vin  [6];
        logic [32:0] vexp [6];
        int waits, lat;
        vin[0] = 64'h4000_0000_4000_0000; vexp[0] = {1'b0, 32'h2000_0000};
        vin[1] = 64'h8000_8000_8000_0000; vexp[1] = {1'b1, 32'h7FFF_7FFF};
        vin[2] = 64'h0001_0000_4000_0000; vexp[2] = {1'b0, 32'h0001_0000};
        vin[3] = 64'hFFFF_0000_4000_0000; vexp[3] = {1'b0, 32'hFFFF_0000};
        vin[4] = 64'h0001_0000_3FFF_0000; vexp[4] = {1'b0, 32'h0000_0000};
        vin[5] = 64'h8000_8000_0000_8000;
`ifdef AXIS_SC16_CMUL_CONJ_EN
        vexp[5] = {1'b0, 32'h7FFF_8001};
`else
        vexp[5] = {1'b1, 32'h8000_7FFF};
`endif
        o_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            send_beat(vin[k], 1'b1, USER_W'(k), waits);
            i_tvalid = 1'b0;
            lat = 0;
            while (lat < 20) begin
                @(negedge clk);
                lat++;
                if (o_tvalid) break;
            end
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL latency_%0d: got %0d cycles need 3", k, lat);
            end
            checks++;
            if ({o_sat, o_tdata} !== vexp[k]) begin
                errors++;
                $display("FAIL directed_%0d: got s=%b d=%h need s=%b d=%h",
                         k, o_sat, o_tdata, vexp[k][32], vexp[k][31:0]);
            end
            @(posedge clk); #1;
        end
        wait_drain("directed");
    endtask

    task automatic test_backpressure();
        bit done = 0;
        int base = out_count;
        int waits;
        fork
            begin
                for (int b = 0; b < 16; b++) begin
                    while ($urandom_range(0, 99) < 30) begin
                        i_tvalid = 1'b0;
                        @(posedge clk); #1;
                    end
                    send_beat({pick_s16(), pick_s16(), pick_s16(), pick_s16()}, b == 15, USER_W'(b), waits);
                end
                i_tvalid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    o_tready = ($urandom_range(0, 99) >= 30);
                    @(posedge clk); #1;
                end
            end
        join
        o_tready = 1'b1;
        wait_drain("backpressure");
        checks++;
        if (out_count - base != 16) begin
            errors++;
            $display("FAIL backpressure_count: got %0d beats need 16", out_count - base);
        end
    endtask

    task automatic test_stall();
        int base = out_count;
        int waits, wsum = 0;
        logic [31:0] snap;
        logic [4:0]  pat;
        o_tready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            send_beat({$urandom, $urandom}, 1'b0, USER_W'(b), waits);
            wsum += waits;
        end
        checks++;
        if (wsum != 0) begin
            errors++;
            $display("FAIL stall_fill: got %0d wait cycles need 0", wsum);
        end
        i_tdata = {$urandom, $urandom}; i_tlast = 1'b1; i_tuser = USER_W'(3); i_tvalid = 1'b1;
        @(negedge clk);
        snap = o_tdata;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (i_tready !== 1'b0 || o_tvalid !== 1'b1 || o_tdata !== snap) begin
                errors++;
                $display("FAIL stall_hold_%0d: got rdy=%b v=%b d=%h need rdy=0 v=1 d=%h",
                         c, i_tready, o_tvalid, o_tdata, snap);
            end
            @(negedge clk);
        end
        @(posedge clk); #1 o_tready = 1'b1;
        @(negedge clk);
        pat[0] = o_tvalid;
        checks++;
        if (i_tready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b need 1", i_tready);
        end
        @(posedge clk); #1 i_tvalid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            pat[k] = o_tvalid;
        end
        checks++;
        if (pat !== 5'b01111) begin
            errors++;
            $display("FAIL stall_rate: got valid pattern %b need 01111", pat);
        end
        wait_drain("stall");
        checks++;
        if (out_count - base != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d beats need 4", out_count - base);
        end
    endtask

    task automatic test_reset_mid();
        int base, waits;
        bit seen = 0;
        o_tready = 1'b1;
        for (int b = 0; b < 3; b++) send_beat({$urandom, $urandom}, 1'b0, USER_W'(b), waits);
        i_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: got v=%b rdy=%b need v=0 rdy=1", o_tvalid, i_tready);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_tvalid) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_stale: got stale o_tvalid=1 need 0");
        end
        @(posedge clk); #1;
        base = out_count;
        for (int b = 0; b < 4; b++) send_beat({pick_s16(), pick_s16(), pick_s16(), pick_s16()}, b == 3, USER_W'(b + 8), waits);
        i_tvalid = 1'b0;
        wait_drain("midreset");
        checks++;
        if (out_count - base != 4) begin
            errors++;
            $display("FAIL midreset_count: got %0d beats need 4", out_count - base);
        end
    endtask

    task automatic test_back_to_back();
        int base = out_count;
        int waits, wsum = 0;
        o_tready = 1'b1;
        for (int b = 0; b < 24; b++) begin
            send_beat({pick_s16(), pick_s16(), pick_s16(), pick_s16()}, b == 23, USER_W'(b), waits);
            wsum += waits;
        end
        i_tvalid = 1'b0;
        checks++;
        if (wsum != 0) begin
            errors++;
            $display("FAIL b2b_rate: got %0d wait cycles need 0", wsum);
        end
        wait_drain("b2b");
        checks++;
        if (out_count - base != 24) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats need 24", out_count - base);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
